dt_skeleton: RTL

- Downstream consumer of the distance-transform stage.
- After the DT stage raises done, this block scans the 128x128 8-bit distance map in the result RAM.
- It marks every local-maximum pixel (the medial-axis approximation), packs the marks 16 pixels per word, and writes them to a 1024x16 skeleton RAM.
- It also reports the maximum distance and the object-pixel count.

---
 rtl/dt_skeleton.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dt_skeleton.sv
// Skeleton extractor: scans the distance map left by the DT stage, marks local maxima,
// packs the marks 16 per word into the skeleton RAM and reports max distance / object count.
module dt_skeleton #(
  parameter int IMG_W = 128,
  parameter int DW    = 8,
  localparam int LW   = $clog2(IMG_W),
  localparam int AW   = 2 * LW,
  localparam int WW   = AW - 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          res_rd,
  output logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_di,
  output logic          skl_wr,
  output logic [WW-1:0] skl_addr,
  output logic [15:0]   skl_do,
  output logic [DW-1:0] max_dist,
  output logic [AW-1:0] obj_cnt,
  output logic          done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_C, S_CHK_C, S_RD_N, S_RD_W, S_RD_E, S_RD_S, S_CMP, S_SHIFT, S_WRITE, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [14:0]   pack_q, pack_d;
  logic [DW-1:0] c_q, c_d;
  logic          mark_q, mark_d;
  logic [DW-1:0] max_q, max_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [WW-1:0] waddr_q, waddr_d;
  logic [15:0]   wdo_q, wdo_d;

  logic [LW-1:0] row_q, col_q, row_n, col_n;
  logic          samp_ok, ge, mark_bit;
  logic [DW-1:0] samp;

  assign row_q = idx_q[AW-1:LW];
  assign col_q = idx_q[LW-1:0];
  assign row_n = idx_d[AW-1:LW];
  assign col_n = idx_d[LW-1:0];

  // Data arriving now belongs to the read issued one state earlier; off-image slots read as 0.
  always_comb begin
    case (state_q)
      S_RD_W:  samp_ok = (row_q != '0);
      S_RD_E:  samp_ok = (col_q != '0);
      S_RD_S:  samp_ok = (col_q != '1);
      S_CMP:   samp_ok = (row_q != '1);
      default: samp_ok = 1'b0;
    endcase
    samp     = samp_ok ? res_di : '0;
    ge       = (c_q >= samp);
    mark_bit = (state_q == S_CMP) ? (mark_q & ge) : mark_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    c_d     = c_q;
    mark_d  = mark_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdo_d   = wdo_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = S_RD_C;
          idx_d   = '0;
          pack_d  = '0;
          max_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_RD_C: state_d = S_CHK_C;
      S_CHK_C: begin
        c_d = res_di;
        if (res_di != '0) begin
          if (cnt_q != '1) cnt_d = cnt_q + AW'(1);
          if (res_di > max_q) max_d = res_di;
          mark_d  = 1'b1;
          state_d = S_RD_N;
        end else begin
          mark_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_RD_N: state_d = S_RD_W;
      S_RD_W: begin mark_d = mark_q & ge; state_d = S_RD_E; end
      S_RD_E: begin mark_d = mark_q & ge; state_d = S_RD_S; end
      S_RD_S: begin mark_d = mark_q & ge; state_d = S_CMP;  end
      // CMP folds in the shift so an object pixel costs 7 cycles; the 16th mark
      // goes straight into the written word.
      S_CMP, S_SHIFT: begin
        pack_d = {pack_q[13:0], mark_bit};
        if (idx_q[3:0] == 4'hF) begin
          state_d = S_WRITE;
          wr_d    = 1'b1;
          waddr_d = idx_q[AW-1:4];
          wdo_d   = {pack_q, mark_bit};
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_RD_C;
        end
      end
      S_WRITE: begin
        pack_d = '0;
        if (idx_q == '1) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_RD_C;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read strobe/address are registered, so they are derived from the state being entered.
  always_comb begin
    rd_d   = 1'b0;
    addr_d = addr_q;
    case (state_d)
      S_RD_C: begin rd_d = 1'b1;             addr_d = idx_d;                end
      S_RD_N: begin rd_d = (row_n != '0);    addr_d = idx_d - AW'(IMG_W);  end
      S_RD_W: begin rd_d = (col_n != '0);    addr_d = idx_d - AW'(1);      end
      S_RD_E: begin rd_d = (col_n != '1);    addr_d = idx_d + AW'(1);      end
      S_RD_S: begin rd_d = (row_n != '1);    addr_d = idx_d + AW'(IMG_W);  end
      default: rd_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pack_q  <= '0;
      c_q     <= '0;
      mark_q  <= 1'b0;
      max_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      c_q     <= c_d;
      mark_q  <= mark_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdo_q   <= wdo_d;
    end
  end

  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign skl_wr   = wr_q;
  assign skl_addr = waddr_q;
  assign skl_do   = wdo_q;
  assign max_dist = max_q;
  assign obj_cnt  = cnt_q;
  assign done     = done_q;

endmodule
